// File: rtl/gbtx_daq_pkg.sv
// Shared constants and state encoding for the GBTx DAQ word scheduler.
// Data words carry the payload with bit 18 cleared; bit 18 set marks an idle word.
package gbtx_daq_pkg;

    localparam int PAYLOAD_W = 18;
    localparam logic [18:0] IDLE_WORD = 19'h40000;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        XFER_A = 3'd1,
        XFER_B = 3'd2,
        FLUSH  = 3'd3,
        GAP    = 3'd4
    } state_e;

    function automatic logic [18:0] mk_data_word(input logic [PAYLOAD_W-1:0] data);
        return {1'b0, data};
    endfunction

endpackage

// File: rtl/gbtx_rr_arb2.sv
// Two-requester round-robin arbiter working at packet granularity.
// The last-served flag only moves on the advance strobe, i.e. when a packet is granted.
module gbtx_rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] grant
);

    logic last_b_r;

    // Grant decode: on contention the requester not served last wins
    always_comb begin
        grant = 2'b00;
        case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = last_b_r ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
    end

    // Last-served register; B after reset so A wins the first contention
    always_ff @(posedge clk) begin
        if (rst) begin
            last_b_r <= 1'b1;
        end else if (advance && (grant != 2'b00)) begin
            last_b_r <= grant[1];
        end else begin
            last_b_r <= last_b_r;
        end
    end

endmodule

// File: rtl/gbtx_daq_sched.sv
// Packet scheduler merging two 18-bit beat streams onto the GBTx DAQ word path.
// Truncates over-long packets (flushing the remainder) and inserts idle gaps between packets.
module gbtx_daq_sched
    import gbtx_daq_pkg::*;
#(
    parameter int MAX_PKT_LEN = 1024,
    parameter int IDLE_GAP    = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 gbt_txrdy,
    input  logic                 a_valid,
    input  logic [PAYLOAD_W-1:0] a_data,
    input  logic                 a_last,
    output logic                 a_ready,
    input  logic                 b_valid,
    input  logic [PAYLOAD_W-1:0] b_data,
    input  logic                 b_last,
    output logic                 b_ready,
    input  logic                 clr_err,
    output logic [18:0]          daq_word,
    output logic [15:0]          pkt_cnt,
    output logic                 err_trunc
);

    localparam int CNT_W = $clog2(MAX_PKT_LEN + 1);
    localparam int GAP_W = (IDLE_GAP > 1) ? $clog2(IDLE_GAP) : 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(MAX_PKT_LEN - 1);
    localparam logic [GAP_W-1:0] GAP_END   = GAP_W'((IDLE_GAP > 0) ? (IDLE_GAP - 1) : 0);
    localparam state_e AFTER_PKT = (IDLE_GAP == 0) ? IDLE : GAP;

    state_e               state_r, state_s;
    logic [CNT_W-1:0]     beat_cnt_r, beat_cnt_s;
    logic [GAP_W-1:0]     gap_cnt_r, gap_cnt_s;
    logic [18:0]          word_r, word_s;
    logic [15:0]          pkt_cnt_r, pkt_cnt_s;
    logic                 err_r, err_s;
    logic                 trunc_s;
    logic                 flush_b_r, flush_b_s;
    logic                 advance_s;
    logic [1:0]           grant_s;
    logic                 sel_b_s;
    logic                 acc_s;
    logic [PAYLOAD_W-1:0] src_data_s;
    logic                 src_last_s;

    gbtx_rr_arb2 u_arb (
        .clk     (clk),
        .rst     (rst),
        .req     ({b_valid, a_valid}),
        .advance (advance_s),
        .grant   (grant_s)
    );

    assign sel_b_s    = (state_r == XFER_B) || ((state_r == FLUSH) && flush_b_r);
    assign acc_s      = sel_b_s ? (b_valid & b_ready) : (a_valid & a_ready);
    assign src_data_s = sel_b_s ? b_data : a_data;
    assign src_last_s = sel_b_s ? b_last : a_last;

    assign daq_word  = word_r;
    assign pkt_cnt   = pkt_cnt_r;
    assign err_trunc = err_r;

    // Ready decode: follow txrdy while transferring, always accept while flushing
    always_comb begin
        a_ready = 1'b0;
        b_ready = 1'b0;
        case (state_r)
            XFER_A: a_ready = gbt_txrdy;
            XFER_B: b_ready = gbt_txrdy;
            FLUSH: begin
                if (flush_b_r) begin
                    b_ready = 1'b1;
                end else begin
                    a_ready = 1'b1;
                end
            end
            default: begin
                a_ready = 1'b0;
                b_ready = 1'b0;
            end
        endcase
    end

    // Next-state, output word, counters and truncation flag
    always_comb begin
        state_s    = state_r;
        beat_cnt_s = beat_cnt_r;
        gap_cnt_s  = gap_cnt_r;
        word_s     = IDLE_WORD;
        pkt_cnt_s  = pkt_cnt_r;
        flush_b_s  = flush_b_r;
        trunc_s    = 1'b0;
        advance_s  = 1'b0;
        case (state_r)
            IDLE: begin
                if (gbt_txrdy && (a_valid || b_valid)) begin
                    advance_s  = 1'b1;
                    beat_cnt_s = {CNT_W{1'b0}};
                    state_s    = grant_s[0] ? XFER_A : XFER_B;
                end else begin
                    state_s = IDLE;
                end
            end
            XFER_A, XFER_B: begin
                if (acc_s) begin
                    word_s = mk_data_word(src_data_s);
                    if (src_last_s) begin
                        pkt_cnt_s  = pkt_cnt_r + 16'd1;
                        beat_cnt_s = {CNT_W{1'b0}};
                        gap_cnt_s  = {GAP_W{1'b0}};
                        state_s    = AFTER_PKT;
                    end else if (beat_cnt_r == LAST_BEAT) begin
                        // Beat MAX_PKT_LEN without last is still forwarded; the rest is dropped
                        trunc_s    = 1'b1;
                        flush_b_s  = (state_r == XFER_B);
                        beat_cnt_s = {CNT_W{1'b0}};
                        state_s    = FLUSH;
                    end else begin
                        beat_cnt_s = beat_cnt_r + CNT_W'(1);
                    end
                end else begin
                    state_s = state_r;
                end
            end
            FLUSH: begin
                if (acc_s && src_last_s) begin
                    gap_cnt_s = {GAP_W{1'b0}};
                    state_s   = AFTER_PKT;
                end else begin
                    state_s = FLUSH;
                end
            end
            GAP: begin
                if (gap_cnt_r == GAP_END) begin
                    gap_cnt_s = {GAP_W{1'b0}};
                    state_s   = IDLE;
                end else begin
                    gap_cnt_s = gap_cnt_r + GAP_W'(1);
                end
            end
            default: state_s = IDLE;
        endcase

        if (trunc_s) begin
            err_s = 1'b1;
        end else if (clr_err) begin
            err_s = 1'b0;
        end else begin
            err_s = err_r;
        end
    end

    // State and registered outputs; reset drops any packet in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= IDLE;
            beat_cnt_r <= {CNT_W{1'b0}};
            gap_cnt_r  <= {GAP_W{1'b0}};
            word_r     <= IDLE_WORD;
            pkt_cnt_r  <= 16'd0;
            err_r      <= 1'b0;
            flush_b_r  <= 1'b0;
        end else begin
            state_r    <= state_s;
            beat_cnt_r <= beat_cnt_s;
            gap_cnt_r  <= gap_cnt_s;
            word_r     <= word_s;
            pkt_cnt_r  <= pkt_cnt_s;
            err_r      <= err_s;
            flush_b_r  <= flush_b_s;
        end
    end

endmodule

// File: doc/gbtx_daq_sched.md
GBTX_DAQ_SCHED -- requirements
Module: gbtx_daq_sched

Interface
REQ-001 SHALL have parameter MAX_PKT_LEN, default 1024: maximum number of beats forwarded per packet.
REQ-002 SHALL have parameter IDLE_GAP, default 2: number of idle words inserted after each packet (0 allowed).
REQ-003 SHALL have port clk, input, 1 bit: the only clock.
REQ-004 SHALL have port rst, input, 1 bit: reset. One clock; reset is synchronous and active-high.
REQ-005 SHALL have port gbt_txrdy, input, 1 bit: GBTx transmitter ready, already synchronous to clk.
REQ-006 SHALL have port a_valid, input, 1 bit: source A (DAQ readout) beat valid.
REQ-007 SHALL have port a_data, input, 18 bits: source A payload.
REQ-008 SHALL have port a_last, input, 1 bit: source A last beat of packet.
REQ-009 SHALL have port a_ready, output, 1 bit: source A beat accepted when a_valid & a_ready.
REQ-010 SHALL have ports b_valid, b_data[17:0], b_last and b_ready for source B (test/slow-control), identical to A.
REQ-011 SHALL have port clr_err, input, 1 bit: clears err_trunc.
REQ-012 SHALL have port daq_word, output, 19 bits: to serializer; bit18=1 means idle/no write, bit18=0 means data in [17:0].
REQ-013 SHALL have port pkt_cnt, output, 16 bits: completed packets, both sources, wrapping.
REQ-014 SHALL have port err_trunc, output, 1 bit: sticky, set when a packet is truncated.

Function
REQ-015 FSM states SHALL be IDLE, XFER_A, XFER_B, FLUSH and GAP.
REQ-016 IDLE: when gbt_txrdy=1 and any valid=1, SHALL grant one source and go to XFER_x on the next cycle; readys SHALL be 0 in IDLE.
REQ-017 Arbitration SHALL be round-robin at packet granularity: if both sources are valid, the source not served last wins; after reset, A wins first.
REQ-018 In XFER_x, x_ready SHALL equal gbt_txrdy; the other ready SHALL be 0.
REQ-019 An accepted beat SHALL appear on daq_word the next cycle as {1'b0, data} (1-cycle latency, registered output).
REQ-020 A cycle with no accepted beat (valid=0 or txrdy=0) SHALL output idle word 19'h40000; the FSM SHALL stay in XFER_x (pause, no abort).
REQ-021 Accepted beat with last=1 SHALL increment pkt_cnt and go to GAP (or to IDLE if IDLE_GAP=0).
REQ-022 Beat counter SHALL count accepted beats per packet. If beat number MAX_PKT_LEN is accepted with last=0, that beat SHALL be forwarded, err_trunc SHALL be set, and the FSM SHALL go to FLUSH.
REQ-023 FLUSH: x_ready SHALL be 1 regardless of gbt_txrdy and beats SHALL be discarded (idle output). On accepted last, go to GAP; pkt_cnt SHALL NOT increment.
REQ-024 GAP: output idle for exactly IDLE_GAP cycles, then IDLE; readys SHALL be 0.
REQ-025 A single-beat packet (last on the first beat) SHALL be legal.
REQ-026 If clr_err and a new truncation occur in the same cycle, set SHALL win.
REQ-027 pkt_cnt SHALL wrap from 0xFFFF to 0.

Reset
REQ-028 On rst=1 at a clk edge: state=IDLE, daq_word=19'h40000, a_ready=b_ready=0, pkt_cnt=0, err_trunc=0, beat counter=0, last-served=B.
REQ-029 Reset mid-packet SHALL abandon the packet with no further words and no count change; the next cycle outputs idle.

Structure
REQ-030 Package gbtx_daq_pkg SHALL hold IDLE_WORD (19'h40000), the state encoding, and the payload width (18).
REQ-031 Two-input round-robin arbiter SHALL be a sub-module gbtx_rr_arb2 (req[1:0], advance strobe, one-hot grant, last-served register).
REQ-032 Beat counter width SHALL be clog2(MAX_PKT_LEN+1).

Verification
REQ-033 Bench SHALL cover: A sends a 3-beat packet 0x00001,0x00002,0x00003 with txrdy=1 -> daq_word 0x00001,0x00002,0x00003 on consecutive cycles, then 2 idles, pkt_cnt=1.
REQ-034 Bench SHALL cover: A and B both valid from reset, 2-beat packets each -> A packet, 2 idles, B packet; pkt_cnt=2.
REQ-035 Bench SHALL cover: txrdy low for 4 cycles mid-packet -> a_ready=0 and 4 idle words, then the remaining beats with no loss or duplication.
REQ-036 Bench SHALL cover: MAX_PKT_LEN=4, A sends 6 beats with last on beat 6 -> 4 data words out, err_trunc=1, pkt_cnt unchanged; clr_err -> 0.
REQ-037 Bench SHALL cover: rst asserted after beat 2 of 5 -> next daq_word is 19'h40000, pkt_cnt=0, and A wins the next arbitration.
REQ-038 Bench SHALL cover: IDLE_GAP=0 with back-to-back single-beat packets from B -> a data word every 2 cycles (IDLE grant cycle in between).
